rf_psum_pingpong_acc: RTL

Parametrised ping-pong psum register file for one PE, with two banks of DEPTH entries. One bank faces the MAC through a registered read port and an accumulate/overwrite write port. The other bank drains to the global-buffer adder through a valid/ready stream, with an internal address counter. Banks swap by a req/ack handshake. Zero-initialisation uses per-entry valid bits, so a bank is cleared in one cycle rather than DEPTH cycles.

---
 rtl/rf_psum_pingpong_acc_if.sv | 35 +++
 rtl/rf_psum_pingpong_acc.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rf_psum_pingpong_acc_if.sv
// Purpose: bundles the MAC-side and drain-side signals of the ping-pong psum register file.
// Ports:   master = PE/MAC controller and drain consumer, slave = register file.
//          MAC read/write port, swap req/ack, drain start/stream/done, current MAC bank.
interface rf_psum_pingpong_acc_if #(
   parameter int DATA_BITWIDTH = 16,
   parameter int ADDR_BITWIDTH = 3
);
   logic [ADDR_BITWIDTH-1:0] mac_rd_addr;
   logic [DATA_BITWIDTH-1:0] mac_rd_data;
   logic                     mac_wr_en;
   logic [ADDR_BITWIDTH-1:0] mac_wr_addr;
   logic [DATA_BITWIDTH-1:0] mac_wr_data;
   logic                     acc_mode;
   logic                     swap_req;
   logic                     swap_ack;
   logic                     drain_start;
   logic                     out_valid;
   logic                     out_ready;
   logic [ADDR_BITWIDTH-1:0] out_addr;
   logic [DATA_BITWIDTH-1:0] out_data;
   logic                     drain_done;
   logic                     mac_sel;

   modport master (
      output mac_rd_addr, mac_wr_en, mac_wr_addr, mac_wr_data, acc_mode,
             swap_req, drain_start, out_ready,
      input  mac_rd_data, swap_ack, out_valid, out_addr, out_data, drain_done, mac_sel
   );

   modport slave (
      input  mac_rd_addr, mac_wr_en, mac_wr_addr, mac_wr_data, acc_mode,
             swap_req, drain_start, out_ready,
      output mac_rd_data, swap_ack, out_valid, out_addr, out_data, drain_done, mac_sel
   );
endinterface

// File: rtl/rf_psum_pingpong_acc.sv
// Purpose: two-bank ping-pong psum register file; one bank serves the MAC (read + accumulate/
//          overwrite), the other drains as a valid/ready stream; banks exchange by swap_req/swap_ack.
// Latency: MAC read 1 cycle; drain word visible the cycle after drain_start, one word per accepted beat.
// Backpressure: out_valid/out_addr/out_data hold while out_ready=0; swap requests during a drain wait.
// Ports: clk, reset (async active-low), bus (slave side of rf_psum_pingpong_acc_if).
module rf_psum_pingpong_acc #(
   parameter int DATA_BITWIDTH = 16,
   parameter int ADDR_BITWIDTH = 3,
   parameter int DEPTH         = 8,
   parameter int SATURATE      = 1
) (
   input logic                   clk,
   input logic                   reset,
   rf_psum_pingpong_acc_if.slave bus
);
   localparam int DW = DATA_BITWIDTH;
   localparam int AW = ADDR_BITWIDTH;
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, DRAIN, LAST} state_t;

   state_t            state_q, state_d;
   logic              mac_sel_q, mac_sel_d;
   logic              pend_q, pend_d;
   logic              swap_ack_q, swap_ack_d;
   logic [AW-1:0]     cnt_q, cnt_d;
   logic [DW-1:0]     rd_data_q, rd_data_d;
   logic [DEPTH-1:0]  vld_q [2];
   logic [DEPTH-1:0]  vld_d [2];
   logic [DW-1:0]     mem_q [2][DEPTH];
   logic [DW-1:0]     mem_d [2][DEPTH];

   logic              rd_in_range, wr_in_range, do_swap, ovf, drain_bank;
   logic [DW-1:0]     wr_old, wr_new;
   logic [DW:0]       sum;

   assign rd_in_range = int'(bus.mac_rd_addr) < DEPTH;
   assign wr_in_range = int'(bus.mac_wr_addr) < DEPTH;
   assign drain_bank  = ~mac_sel_q;

   // An entry whose valid bit is clear reads as zero; that is how a bank is cleared in one cycle.
   assign wr_old = vld_q[mac_sel_q][bus.mac_wr_addr] ? mem_q[mac_sel_q][bus.mac_wr_addr] : '0;

   // One extra bit of sign: overflow whenever the two top bits of the sum disagree.
   assign sum = {wr_old[DW-1], wr_old} + {bus.mac_wr_data[DW-1], bus.mac_wr_data};
   assign ovf = sum[DW] ^ sum[DW-1];

   always_comb begin
      wr_new = bus.mac_wr_data;
      if (bus.acc_mode) begin
         if ((SATURATE != 0) && ovf) begin
            wr_new = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
         end else begin
            wr_new = sum[DW-1:0];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      mac_sel_d  = mac_sel_q;
      pend_d     = pend_q;
      swap_ack_d = 1'b0;
      cnt_d      = cnt_q;
      vld_d      = vld_q;
      mem_d      = mem_q;
      do_swap    = 1'b0;
      // Read samples state before this edge's write: read-before-write.
      rd_data_d  = '0;
      if (rd_in_range && vld_q[mac_sel_q][bus.mac_rd_addr]) begin
         rd_data_d = mem_q[mac_sel_q][bus.mac_rd_addr];
      end

      if (bus.mac_wr_en && wr_in_range) begin
         mem_d[mac_sel_q][bus.mac_wr_addr] = wr_new;
         vld_d[mac_sel_q][bus.mac_wr_addr] = 1'b1;
      end

      case (state_q)
         IDLE: begin
            // A swap and a drain start in the same cycle: the swap wins.
            if (bus.swap_req) begin
               do_swap = 1'b1;
            end else if (bus.drain_start) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end
         end
         DRAIN: begin
            if (bus.swap_req) begin
               pend_d = 1'b1;
            end
            if (bus.out_ready) begin
               if (cnt_q == LAST_IDX) begin
                  state_d = LAST;
               end else begin
                  cnt_d = cnt_q + AW'(1);
               end
            end
         end
         LAST: begin
            vld_d[drain_bank] = '0;
            do_swap           = pend_q | bus.swap_req;
            pend_d            = 1'b0;
            state_d           = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // The bank turning to face the MAC starts empty; the MAC write of this edge
      // still lands in the outgoing bank.
      if (do_swap) begin
         vld_d[drain_bank] = '0;
         mac_sel_d         = ~mac_sel_q;
         swap_ack_d        = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         mac_sel_q  <= 1'b0;
         pend_q     <= 1'b0;
         swap_ack_q <= 1'b0;
         cnt_q      <= '0;
         rd_data_q  <= '0;
         vld_q[0]   <= '0;
         vld_q[1]   <= '0;
      end else begin
         state_q    <= state_d;
         mac_sel_q  <= mac_sel_d;
         pend_q     <= pend_d;
         swap_ack_q <= swap_ack_d;
         cnt_q      <= cnt_d;
         rd_data_q  <= rd_data_d;
         vld_q      <= vld_d;
      end
   end

   // Storage is never reset; validity lives in vld_q.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign bus.mac_rd_data = rd_data_q;
   assign bus.swap_ack    = swap_ack_q;
   assign bus.out_valid   = (state_q == DRAIN);
   assign bus.out_addr    = cnt_q;
   assign bus.out_data    = vld_q[drain_bank][cnt_q] ? mem_q[drain_bank][cnt_q] : '0;
   assign bus.drain_done  = (state_q == LAST);
   assign bus.mac_sel     = mac_sel_q;
endmodule
